imem_boot_loader: RTL



---
 rtl/riscv_pkg.sv | 13 +
 rtl/imem_boot_loader_byte_packer.sv | 52 +++++
 rtl/imem_boot_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and FSM state encoding for the IMEM boot loader and IMEM block.
package riscv_pkg;
  localparam int          IMEM_DEPTH = 64;
  localparam int          IMEM_AW    = 6;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_RUN  = 2'd3
  } ld_state_e;
endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Collects little-endian bytes from a valid/ready stream into 32-bit words.
// A completed word is presented for exactly one cycle on o_word_vld.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic        i_ready,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_word_vld,
  output logic [1:0]  o_byte_idx
);
  logic [23:0] r_acc;
  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic        r_word_vld;
  logic        w_take;

  assign w_take     = i_valid && i_ready;
  assign o_word     = r_word;
  assign o_word_vld = r_word_vld;
  assign o_byte_idx = r_idx;

  // Byte accumulation; the 4th byte completes the word and fires a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      if (i_clr) begin
        r_acc <= '0;
        r_idx <= '0;
      end else if (w_take) begin
        case (r_idx)
          2'd0: r_acc[7:0]   <= i_data;
          2'd1: r_acc[15:8]  <= i_data;
          2'd2: r_acc[23:16] <= i_data;
          default: begin
            r_word     <= {i_data, r_acc};
            r_word_vld <= 1'b1;
            r_acc      <= '0;
          end
        endcase
        r_idx <= r_idx + 2'd1;
      end
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// Boot/reload loader: owns the IMEM write port, holds the core in reset while
// a program is streamed in, and steers the IMEM read port to fetch only in RUN.
module imem_boot_loader
  import riscv_pkg::*;
#(
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter int          AW        = IMEM_AW,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [AW:0]   ld_words,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  input  logic [31:0]   imem_rd,
  output logic [31:0]   imem_addr,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst,
  output logic          busy,
  output logic          load_done,
  output logic [31:0]   checksum
);
  localparam logic [AW:0] LP_DEPTH = DEPTH[AW:0];

  ld_state_e   r_state, w_state_nxt;
  logic [AW:0] r_len;
  logic [AW:0] r_wcnt;
  logic [31:0] r_csum;
  logic        r_ld_ready;

  logic        w_start;
  logic        w_hs;
  logic        w_last_hs;
  logic        w_last_wr;
  logic [31:0] w_word;
  logic        w_word_vld;
  logic [1:0]  w_byte_idx;

  assign w_start   = ld_start && (r_state == ST_HOLD || r_state == ST_RUN);
  assign w_hs      = ld_valid && r_ld_ready;
  // Final byte of the final word: stop accepting so excess bytes stay upstream.
  assign w_last_hs = w_hs && (w_byte_idx == 2'd3) && ((r_wcnt + 1'b1) == r_len);
  assign w_last_wr = w_word_vld && ((r_wcnt + 1'b1) == r_len);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_start),
    .i_valid   (ld_valid),
    .i_ready   (r_ld_ready),
    .i_data    (ld_data),
    .o_word    (w_word),
    .o_word_vld(w_word_vld),
    .o_byte_idx(w_byte_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_HOLD;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic plus state-decoded outputs and the IMEM read arbitration.
  always_comb begin
    w_state_nxt = r_state;
    core_rst    = 1'b1;
    busy        = 1'b0;
    load_done   = 1'b0;
    imem_addr   = 32'h0;
    fetch_instr = NOP_INSTR;
    case (r_state)
      ST_HOLD: begin
        // A zero-length request still passes through DONE so the handshake completes.
        if (ld_start) w_state_nxt = (ld_words == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (w_last_wr) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        load_done   = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: begin
        core_rst    = 1'b0;
        imem_addr   = fetch_addr;
        fetch_instr = imem_rd;
        if (ld_start) w_state_nxt = (ld_words == '0) ? ST_DONE : ST_LOAD;
      end
    endcase
  end

  // Load bookkeeping: clamped length, word counter and running checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len  <= '0;
      r_wcnt <= '0;
      r_csum <= '0;
    end else if (w_start) begin
      r_len  <= (ld_words > LP_DEPTH) ? LP_DEPTH : ld_words;
      r_wcnt <= '0;
      r_csum <= '0;
    end else if (w_word_vld) begin
      r_wcnt <= r_wcnt + 1'b1;
      r_csum <= r_csum + w_word;
    end
  end

  // ld_ready: raised on entry to LOAD, dropped after the last needed byte and held low.
  always_ff @(posedge clk) begin
    if (rst)                    r_ld_ready <= 1'b0;
    else if (r_state != ST_LOAD) r_ld_ready <= (w_state_nxt == ST_LOAD);
    else                        r_ld_ready <= r_ld_ready && !w_last_hs && (w_state_nxt == ST_LOAD);
  end

  assign ld_ready   = r_ld_ready;
  assign imem_we    = w_word_vld;
  assign imem_waddr = r_wcnt[AW-1:0];
  assign imem_wdata = w_word;
  assign checksum   = r_csum;
endmodule
